mode_controller: RTL and testbench

- Top-level sequencer for the clock/timer/stopwatch design.
- Selects one active mode, drives the per-mode enable lines, and routes the four shared user buttons to the active mode only.
- Multiplexes the active mode's 4 BCD digits onto a scanned 4-digit display.
- Runs the buzzer pattern, display flashing and auto-silence timeout while the timer alarm is active.

---
 rtl/mode_controller.sv | 251 +++++++++++++++++++++++++
 tb/tb_mode_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mode_controller.sv
// Top-level sequencer: mode selection, button routing, scanned display and alarm handling
// for the clock/timer/stopwatch design.
module mode_controller #(
    parameter int CLK_FREQ        = 1000,
    parameter int SCAN_DIV        = 2,
    parameter int BEEP_HALF       = 250,
    parameter int ALARM_TIMEOUT_S = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic        btn_c,
    input  logic        btn_d,
    input  logic        timer_active,
    input  logic        timer_alarm,
    input  logic [15:0] clk_digits,
    input  logic [15:0] tmr_digits,
    input  logic [15:0] sw_digits,
    output logic        en_clock,
    output logic        en_timer,
    output logic        en_stopwatch,
    output logic [3:0]  clk_btn,
    output logic [3:0]  sw_btn,
    output logic [4:0]  tmr_btn,
    output logic [3:0]  seg_sel,
    output logic [3:0]  seg_bcd,
    output logic        buzzer,
    output logic [2:0]  mode_led
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BEEP_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam int PRE_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int SEC_W  = (ALARM_TIMEOUT_S > 1) ? $clog2(ALARM_TIMEOUT_S) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_FREQ - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(ALARM_TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        ST_CLOCK     = 2'd0,
        ST_TIMER     = 2'd1,
        ST_STOPWATCH = 2'd2
    } mode_t;

    mode_t             state_r;
    mode_t             state_nx_s;
    logic              btn_mode_q_r;
    logic              mask_r;
    logic [SCAN_W-1:0] scan_cnt_r;
    logic [1:0]        digit_idx_r;
    logic [BEEP_W-1:0] beep_cnt_r;
    logic              buzz_off_r;
    logic [PRE_W-1:0]  pre_cnt_r;
    logic [SEC_W-1:0]  sec_cnt_r;
    logic              silenced_r;
    logic [2:0]        en_r;

    logic        mode_edge_s;
    logic        mode_lock_s;
    logic        advance_s;
    logic        btn_any_s;
    logic        auto_stop_s;
    logic [3:0]  btn_vec_s;
    logic [15:0] src_digits_s;
    logic [2:0]  en_nx_s;
    logic [3:0]  clk_btn_nx_s;
    logic [3:0]  sw_btn_nx_s;
    logic [4:0]  tmr_btn_nx_s;
    logic [3:0]  seg_sel_nx_s;
    logic [3:0]  seg_bcd_nx_s;
    logic        buzzer_nx_s;

    assign btn_vec_s   = {btn_d, btn_c, btn_b, btn_a};
    assign btn_any_s   = btn_a | btn_b | btn_c | btn_d;
    assign mode_edge_s = btn_mode & ~btn_mode_q_r;
    // Leaving TIMER would disable it and kill a running countdown or alarm.
    assign mode_lock_s = (state_r == ST_TIMER) & (timer_active | timer_alarm);
    assign advance_s   = mode_edge_s & ~mode_lock_s;
    assign auto_stop_s = timer_alarm & ~silenced_r & (pre_cnt_r == PRE_LAST) &
                         (sec_cnt_r == SEC_LAST);

    assign en_clock     = en_r[0];
    assign en_timer     = en_r[1];
    assign en_stopwatch = en_r[2];
    assign mode_led     = en_r;

    // Mode state register and btn_mode edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_CLOCK;
            btn_mode_q_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            btn_mode_q_r <= btn_mode;
        end
    end

    // Next mode: one step around the ring per accepted btn_mode edge.
    always_comb begin
        state_nx_s = state_r;
        if (advance_s) begin
            case (state_r)
                ST_CLOCK:     state_nx_s = ST_TIMER;
                ST_TIMER:     state_nx_s = ST_STOPWATCH;
                ST_STOPWATCH: state_nx_s = ST_CLOCK;
                default:      state_nx_s = ST_CLOCK;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Next values of all registered outputs.
    always_comb begin
        en_nx_s      = 3'b001;
        clk_btn_nx_s = 4'b0000;
        sw_btn_nx_s  = 4'b0000;
        tmr_btn_nx_s = 5'b00000;
        src_digits_s = clk_digits;
        seg_sel_nx_s = 4'b1111;
        seg_bcd_nx_s = 4'h0;
        buzzer_nx_s  = timer_alarm & ~buzz_off_r;

        case (state_nx_s)
            ST_CLOCK:     begin en_nx_s = 3'b001; src_digits_s = clk_digits; end
            ST_TIMER:     begin en_nx_s = 3'b010; src_digits_s = tmr_digits; end
            ST_STOPWATCH: begin en_nx_s = 3'b100; src_digits_s = sw_digits;  end
            default:      begin en_nx_s = 3'b001; src_digits_s = clk_digits; end
        endcase

        if (!(advance_s | mask_r)) begin
            case (state_r)
                ST_CLOCK:     clk_btn_nx_s = btn_vec_s;
                ST_TIMER:     tmr_btn_nx_s = {btn_d, btn_d, btn_c, btn_b, btn_a};
                ST_STOPWATCH: sw_btn_nx_s  = btn_vec_s;
                default:      clk_btn_nx_s = 4'b0000;
            endcase
        end else begin
            clk_btn_nx_s = 4'b0000;
        end
        // Auto-stop is not a user press, so the mask does not hold it back.
        if (state_r == ST_TIMER) begin
            tmr_btn_nx_s[4] = tmr_btn_nx_s[4] | auto_stop_s;
        end else begin
            tmr_btn_nx_s[4] = 1'b0;
        end

        case (digit_idx_r)
            2'd0:    begin seg_sel_nx_s = 4'b1110; seg_bcd_nx_s = src_digits_s[3:0];   end
            2'd1:    begin seg_sel_nx_s = 4'b1101; seg_bcd_nx_s = src_digits_s[7:4];   end
            2'd2:    begin seg_sel_nx_s = 4'b1011; seg_bcd_nx_s = src_digits_s[11:8];  end
            2'd3:    begin seg_sel_nx_s = 4'b0111; seg_bcd_nx_s = src_digits_s[15:12]; end
            default: begin seg_sel_nx_s = 4'b1111; seg_bcd_nx_s = 4'h0;                end
        endcase
        if (timer_alarm & buzz_off_r) begin
            seg_sel_nx_s = 4'b1111;
        end else begin
            seg_sel_nx_s = seg_sel_nx_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_r    <= 3'b001;
            clk_btn <= 4'b0000;
            sw_btn  <= 4'b0000;
            tmr_btn <= 5'b00000;
            seg_sel <= 4'b1111;
            seg_bcd <= 4'h0;
            buzzer  <= 1'b0;
        end else begin
            en_r    <= en_nx_s;
            clk_btn <= clk_btn_nx_s;
            sw_btn  <= sw_btn_nx_s;
            tmr_btn <= tmr_btn_nx_s;
            seg_sel <= seg_sel_nx_s;
            seg_bcd <= seg_bcd_nx_s;
            buzzer  <= buzzer_nx_s;
        end
    end

    // Button mask: a button held across a mode change must be released before it counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_r <= 1'b1;
        end else if (advance_s) begin
            mask_r <= 1'b1;
        end else if (!btn_any_s) begin
            mask_r <= 1'b0;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Display scan counters, free-running across mode changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= 2'd0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= (digit_idx_r == 2'd3) ? 2'd0 : digit_idx_r + 2'd1;
        end else begin
            scan_cnt_r  <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // Buzzer phase and auto-silence timing, active only while the alarm is on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beep_cnt_r <= '0;
            buzz_off_r <= 1'b0;
            pre_cnt_r  <= '0;
            sec_cnt_r  <= '0;
            silenced_r <= 1'b0;
        end else if (!timer_alarm) begin
            beep_cnt_r <= '0;
            buzz_off_r <= 1'b0;
            pre_cnt_r  <= '0;
            sec_cnt_r  <= '0;
            silenced_r <= 1'b0;
        end else begin
            if (beep_cnt_r == BEEP_LAST) begin
                beep_cnt_r <= '0;
                buzz_off_r <= ~buzz_off_r;
            end else begin
                beep_cnt_r <= beep_cnt_r + BEEP_W'(1);
            end
            if (!silenced_r) begin
                if (pre_cnt_r == PRE_LAST) begin
                    pre_cnt_r <= '0;
                    if (sec_cnt_r == SEC_LAST) begin
                        silenced_r <= 1'b1;
                    end else begin
                        sec_cnt_r <= sec_cnt_r + SEC_W'(1);
                    end
                end else begin
                    pre_cnt_r <= pre_cnt_r + PRE_W'(1);
                end
            end else begin
                pre_cnt_r <= pre_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller: reset, mode ring and lock, button routing and mask,
// display scan, buzzer/flash pattern and auto-silence.
module tb_mode_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_mode, btn_a, btn_b, btn_c, btn_d;
    logic        timer_active, timer_alarm;
    logic [15:0] clk_digits, tmr_digits, sw_digits;
    logic        en_clock, en_timer, en_stopwatch;
    logic [3:0]  clk_btn, sw_btn;
    logic [4:0]  tmr_btn;
    logic [3:0]  seg_sel, seg_bcd;
    logic        buzzer;
    logic [2:0]  mode_led;

    int errors = 0;
    int checks = 0;
    int cyc;

    mode_controller #(
        .CLK_FREQ(1000), .SCAN_DIV(2), .BEEP_HALF(250), .ALARM_TIMEOUT_S(2)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode),
        .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c), .btn_d(btn_d),
        .timer_active(timer_active), .timer_alarm(timer_alarm),
        .clk_digits(clk_digits), .tmr_digits(tmr_digits), .sw_digits(sw_digits),
        .en_clock(en_clock), .en_timer(en_timer), .en_stopwatch(en_stopwatch),
        .clk_btn(clk_btn), .sw_btn(sw_btn), .tmr_btn(tmr_btn),
        .seg_sel(seg_sel), .seg_bcd(seg_bcd), .buzzer(buzzer), .mode_led(mode_led)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the digit shown after edge n is index ((n-1)/2)%4.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        tick();
    endtask

    task automatic check_mode(input string tag, input logic [2:0] exp);
        check_eq(tag, {29'd0, mode_led}, {29'd0, exp});
        check_eq({tag, "_en"}, {29'd0, en_stopwatch, en_timer, en_clock}, {29'd0, exp});
    endtask

    function automatic logic [3:0] exp_sel(input int n);
        case (((n - 1) / 2) % 4)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [3:0] exp_nib(input logic [15:0] d, input int n);
        int i;
        i = ((n - 1) / 2) % 4;
        return d[i*4 +: 4];
    endfunction

    initial begin
        int stop_cnt;
        int stop_first;
        rst = 1'b0;
        btn_mode = 1'b0; btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0; btn_d = 1'b0;
        timer_active = 1'b0; timer_alarm = 1'b0;
        clk_digits = 16'h1234; tmr_digits = 16'h5678; sw_digits = 16'h9abc;
        stop_cnt = 0; stop_first = 0;

        tick(); tick();
        check_mode("rst_mode", 3'b001);
        check_eq("rst_btn", {19'd0, clk_btn, sw_btn, tmr_btn}, 32'd0);
        check_eq("rst_sel", {28'd0, seg_sel}, 32'hf);
        check_eq("rst_bcd", {28'd0, seg_bcd}, 32'h0);
        check_eq("rst_buzz", {31'd0, buzzer}, 32'd0);

        rst = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check_eq("scan_sel", {28'd0, seg_sel}, {28'd0, exp_sel(cyc)});
            check_eq("scan_bcd", {28'd0, seg_bcd}, {28'd0, exp_nib(clk_digits, cyc)});
        end

        pulse_mode(); check_mode("ring1", 3'b010);
        pulse_mode(); check_mode("ring2", 3'b100);
        pulse_mode(); check_mode("ring3", 3'b001);

        pulse_mode(); check_mode("lock_pre", 3'b010);
        timer_active = 1'b1;
        pulse_mode(); check_mode("lock_active", 3'b010);
        timer_active = 1'b0;
        pulse_mode(); check_mode("unlock", 3'b100);
        pulse_mode(); check_mode("back_clock", 3'b001);

        pulse_mode(); check_mode("to_timer", 3'b010);
        btn_a = 1'b1; tick();
        check_eq("tmr_start", {27'd0, tmr_btn}, 32'b00001);
        check_eq("tmr_others", {24'd0, clk_btn, sw_btn}, 32'd0);
        btn_a = 1'b0; btn_d = 1'b1; tick();
        check_eq("tmr_d", {27'd0, tmr_btn}, 32'b11000);
        btn_d = 1'b0; btn_b = 1'b1; tick();
        check_eq("tmr_min", {27'd0, tmr_btn}, 32'b00010);
        btn_mode = 1'b1; tick();
        check_mode("held_switch", 3'b100);
        check_eq("held_sw0", {28'd0, sw_btn}, 32'd0);
        check_eq("held_tmr0", {27'd0, tmr_btn}, 32'd0);
        btn_mode = 1'b0; tick(); tick();
        check_eq("held_sw1", {28'd0, sw_btn}, 32'd0);
        btn_b = 1'b0; tick();
        check_eq("release_sw", {28'd0, sw_btn}, 32'd0);
        btn_b = 1'b1; tick();
        check_eq("fresh_sw", {28'd0, sw_btn}, 32'b0010);
        check_eq("fresh_tmr", {27'd0, tmr_btn}, 32'd0);
        check_eq("sw_bcd", {28'd0, seg_bcd}, {28'd0, exp_nib(sw_digits, cyc)});
        btn_b = 1'b0; tick();

        pulse_mode(); check_mode("to_clock", 3'b001);
        btn_a = 1'b1; btn_c = 1'b1; tick();
        check_eq("clk_pass", {28'd0, clk_btn}, 32'b0101);
        check_eq("clk_sw0", {28'd0, sw_btn}, 32'd0);
        btn_a = 1'b0; btn_c = 1'b0; tick();

        pulse_mode(); check_mode("alarm_timer", 3'b010);
        timer_alarm = 1'b1; btn_mode = 1'b1; tick();
        check_mode("lock_alarm", 3'b010);
        check_eq("buzz_first", {31'd0, buzzer}, 32'd1);
        btn_mode = 1'b0;
        for (int k = 2; k <= 2200; k++) begin
            tick();
            if (tmr_btn[4]) begin
                stop_cnt++;
                if (stop_first == 0) stop_first = k;
            end
            if (k == 250) check_eq("buzz_250", {31'd0, buzzer}, 32'd1);
            if (k == 251) begin
                check_eq("buzz_251", {31'd0, buzzer}, 32'd0);
                check_eq("flash_251", {28'd0, seg_sel}, 32'hf);
            end
            if (k == 500) check_eq("buzz_500", {31'd0, buzzer}, 32'd0);
            if (k == 501) begin
                check_eq("buzz_501", {31'd0, buzzer}, 32'd1);
                check_eq("sel_501", {28'd0, seg_sel}, {28'd0, exp_sel(cyc)});
            end
        end
        check_eq("auto_stop_cnt", stop_cnt, 32'd1);
        check_eq("auto_stop_at", stop_first, 32'd2000);
        timer_alarm = 1'b0; tick();
        check_eq("alarm_off_buzz", {31'd0, buzzer}, 32'd0);
        check_eq("alarm_off_sel", {28'd0, seg_sel}, {28'd0, exp_sel(cyc)});
        pulse_mode(); check_mode("post_alarm", 3'b100);

        pulse_mode(); pulse_mode(); check_mode("re_timer", 3'b010);
        timer_alarm = 1'b1; tick(); tick(); tick();
        check_eq("mid_alarm_buzz", {31'd0, buzzer}, 32'd1);
        rst = 1'b0; #2;
        check_eq("async_buzz", {31'd0, buzzer}, 32'd0);
        check_mode("async_mode", 3'b001);
        check_eq("async_sel", {28'd0, seg_sel}, 32'hf);
        timer_alarm = 1'b0; tick();
        rst = 1'b1; tick();
        check_mode("after_rst", 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
